// File: rtl/sal_dfi_cmd_decoder.sv
// DFI command decoder: JEDEC DDR2 decode, per-bank open tracking, rd_en window, violation flags.
// Optional timing checks (codes 5-9) are built only when SAL_DEC_TIMING_CHK_EN is defined.
module sal_dfi_cmd_decoder #(
  parameter int NUM_BANKS  = 4,
  parameter int BA_WIDTH   = $clog2(NUM_BANKS),
  parameter int ADDR_WIDTH = 16,
  parameter int TW         = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dfi_cke,
  input  logic                  dfi_cs_n,
  input  logic                  dfi_ras_n,
  input  logic                  dfi_cas_n,
  input  logic                  dfi_we_n,
  input  logic [BA_WIDTH-1:0]   dfi_ba,
  input  logic [ADDR_WIDTH-1:0] dfi_addr,
  input  logic [TW-1:0]         t_rcd,
  input  logic [TW-1:0]         t_rp,
  input  logic [TW-1:0]         t_ras,
  input  logic [TW-1:0]         t_rfc,
  input  logic [TW-1:0]         t_ccd,
  input  logic [TW-1:0]         rd_lat,
  output logic                  cmd_valid_o,
  output logic [2:0]            cmd_o,
  output logic [BA_WIDTH-1:0]   cmd_ba_o,
  output logic [ADDR_WIDTH-1:0] cmd_addr_o,
  output logic [NUM_BANKS-1:0]  bank_open_o,
  output logic                  rd_en_o,
  output logic                  err_o,
  output logic [3:0]            err_code_o
);

  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_ACT  = 3'd1,
    CMD_RD   = 3'd2,
    CMD_WR   = 3'd3,
    CMD_PRE  = 3'd4,
    CMD_PREA = 3'd5,
    CMD_REF  = 3'd6,
    CMD_MRS  = 3'd7
  } cmd_e;

  typedef enum logic {BANK_CLOSED = 1'b0, BANK_OPEN = 1'b1} bank_st_e;

  cmd_e        w_cmd;
  logic        w_illegal;
  logic        w_valid;
  logic        w_rdwr;
  logic        w_tgt_open;
  logic        w_any_open;
  logic [3:0]  w_err_code;
  bank_st_e    r_bank_st  [NUM_BANKS];
  bank_st_e    w_bank_nxt [NUM_BANKS];
  logic [31:0] r_rd_sr;

  // ras/cas/we are only looked at when the chip is selected, so X there never leaks out
  always_comb begin
    w_cmd     = CMD_NOP;
    w_illegal = 1'b0;
    if (dfi_cke && !dfi_cs_n) begin
      case ({dfi_ras_n, dfi_cas_n, dfi_we_n})
        3'b011:  w_cmd = CMD_ACT;
        3'b101:  w_cmd = CMD_RD;
        3'b100:  w_cmd = CMD_WR;
        3'b010:  w_cmd = dfi_addr[10] ? CMD_PREA : CMD_PRE;
        3'b001:  w_cmd = CMD_REF;
        3'b000:  w_cmd = CMD_MRS;
        3'b110:  w_illegal = 1'b1;
        default: w_cmd = CMD_NOP;
      endcase
    end
  end

  assign w_valid    = (w_cmd != CMD_NOP);
  assign w_rdwr     = (w_cmd == CMD_RD) || (w_cmd == CMD_WR);
  assign w_tgt_open = (r_bank_st[dfi_ba] == BANK_OPEN);
  assign w_any_open = |bank_open_o;
  assign rd_en_o    = r_rd_sr[0];

  always_comb begin
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      bank_open_o[i] = (r_bank_st[i] == BANK_OPEN);
      w_bank_nxt[i]  = r_bank_st[i];
      if (w_cmd == CMD_PREA) begin
        w_bank_nxt[i] = BANK_CLOSED;
      end else if (dfi_ba == BA_WIDTH'(i)) begin
        if (w_cmd == CMD_ACT)      w_bank_nxt[i] = BANK_OPEN;
        else if (w_cmd == CMD_PRE) w_bank_nxt[i] = BANK_CLOSED;
      end
    end
  end

`ifdef SAL_DEC_TIMING_CHK_EN
  logic [TW-1:0] r_rcd [NUM_BANKS];
  logic [TW-1:0] r_ras [NUM_BANKS];
  logic [TW-1:0] r_rp  [NUM_BANKS];
  logic [TW-1:0] r_rfc;
  logic [TW-1:0] r_ccd;

  function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  // A counter loaded with t at the command edge reads t-(d-1) d cycles later, so d < t <=> count > 1
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_BANKS; i++) begin
        r_rcd[i] <= '0;
        r_ras[i] <= '0;
        r_rp[i]  <= '0;
      end
      r_rfc <= '0;
      r_ccd <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_BANKS; i++) begin
        r_rcd[i] <= dec_sat(r_rcd[i]);
        r_ras[i] <= dec_sat(r_ras[i]);
        r_rp[i]  <= dec_sat(r_rp[i]);
        if (w_cmd == CMD_ACT && dfi_ba == BA_WIDTH'(i)) begin
          r_rcd[i] <= t_rcd;
          r_ras[i] <= t_ras;
        end
        if ((w_cmd == CMD_PRE && dfi_ba == BA_WIDTH'(i)) || w_cmd == CMD_PREA)
          r_rp[i] <= t_rp;
      end
      r_rfc <= (w_cmd == CMD_REF) ? t_rfc : dec_sat(r_rfc);
      r_ccd <= w_rdwr ? t_ccd : dec_sat(r_ccd);
    end
  end
`else
  logic w_unused_timing;
  assign w_unused_timing = ^{t_rcd, t_rp, t_ras, t_rfc, t_ccd};
`endif

  always_comb begin
    w_err_code = '0;
    if (w_illegal)                                   w_err_code = 4'd1;
    else if (w_cmd == CMD_ACT && w_tgt_open)         w_err_code = 4'd2;
    else if (w_rdwr && !w_tgt_open)                  w_err_code = 4'd3;
    else if (w_cmd == CMD_REF && w_any_open)         w_err_code = 4'd4;
`ifdef SAL_DEC_TIMING_CHK_EN
    else if (w_rdwr && r_rcd[dfi_ba] > TW'(1))               w_err_code = 4'd5;
    else if (w_cmd == CMD_PRE && r_ras[dfi_ba] > TW'(1))     w_err_code = 4'd6;
    else if (w_cmd == CMD_ACT && r_rp[dfi_ba] > TW'(1))      w_err_code = 4'd7;
    else if (w_valid && r_rfc > TW'(1))                      w_err_code = 4'd8;
    else if (w_rdwr && r_ccd > TW'(1))                       w_err_code = 4'd9;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_valid_o <= 1'b0;
      cmd_o       <= '0;
      cmd_ba_o    <= '0;
      cmd_addr_o  <= '0;
      err_o       <= 1'b0;
      err_code_o  <= '0;
      r_rd_sr     <= '0;
      for (int unsigned i = 0; i < NUM_BANKS; i++) r_bank_st[i] <= BANK_CLOSED;
    end else begin
      cmd_valid_o <= w_valid;
      cmd_o       <= w_cmd;
      cmd_ba_o    <= w_valid ? dfi_ba : '0;
      cmd_addr_o  <= w_valid ? dfi_addr : '0;
      err_o       <= (w_err_code != '0);
      err_code_o  <= w_err_code;
      // taps rd_lat and rd_lat+1 reach bit 0 after edges N+rd_lat and N+rd_lat+1
      r_rd_sr     <= (r_rd_sr >> 1) | ((w_cmd == CMD_RD) ? (32'd3 << rd_lat) : '0);
      for (int unsigned i = 0; i < NUM_BANKS; i++) r_bank_st[i] <= w_bank_nxt[i];
    end
  end

endmodule

// File: tb/tb_sal_dfi_cmd_decoder.sv
// Bench for sal_dfi_cmd_decoder: cycle-distance reference model, per-cycle compare, directed literals, random traffic.
module tb_sal_dfi_cmd_decoder;

`ifdef SAL_DEC_TIMING_CHK_EN
  localparam bit TCHK = 1'b1;
`else
  localparam bit TCHK = 1'b0;
`endif

  localparam logic [2:0] E_ACT = 3'b011, E_RD = 3'b101, E_WR = 3'b100, E_PRE = 3'b010;
  localparam logic [2:0] E_REF = 3'b001, E_MRS = 3'b000, E_NOP = 3'b111, E_ILL = 3'b110;
  localparam int SCHED = 16384;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cke = 1'b1, cs_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
  logic [1:0]  ba = '0;
  logic [15:0] addr = '0;
  logic [4:0]  t_rcd = 5'd4, t_rp = 5'd3, t_ras = 5'd6, t_rfc = 5'd10, t_ccd = 5'd2, rd_lat = 5'd5;

  logic        cmd_valid_o;
  logic [2:0]  cmd_o;
  logic [1:0]  cmd_ba_o;
  logic [15:0] cmd_addr_o;
  logic [3:0]  bank_open_o;
  logic        rd_en_o, err_o;
  logic [3:0]  err_code_o;

  sal_dfi_cmd_decoder #(.NUM_BANKS(4), .ADDR_WIDTH(16), .TW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .dfi_cke(cke), .dfi_cs_n(cs_n), .dfi_ras_n(ras_n), .dfi_cas_n(cas_n), .dfi_we_n(we_n),
    .dfi_ba(ba), .dfi_addr(addr),
    .t_rcd(t_rcd), .t_rp(t_rp), .t_ras(t_ras), .t_rfc(t_rfc), .t_ccd(t_ccd), .rd_lat(rd_lat),
    .cmd_valid_o(cmd_valid_o), .cmd_o(cmd_o), .cmd_ba_o(cmd_ba_o), .cmd_addr_o(cmd_addr_o),
    .bank_open_o(bank_open_o), .rd_en_o(rd_en_o), .err_o(err_o), .err_code_o(err_code_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // Reference model state: open flags and the cycle of the last relevant command
  logic [3:0] m_open = '0;
  int last_act [4];
  int last_pre [4];
  int last_ref, last_ccd;
  bit sched [SCHED];
  int exp_valid, exp_cmd, exp_ba, exp_addr, exp_open, exp_rd, exp_err, exp_code;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_open = '0;
    for (int b = 0; b < 4; b++) begin
      last_act[b] = -1000;
      last_pre[b] = -1000;
    end
    last_ref = -1000;
    last_ccd = -1000;
    for (int k = cyc; k < cyc + 40 && k < SCHED; k++) sched[k] = 1'b0;
    exp_valid = 0; exp_cmd = 0; exp_ba = 0; exp_addr = 0;
    exp_open = 0; exp_rd = 0; exp_err = 0; exp_code = 0;
  endtask

  task automatic model_edge();
    int c, code, b;
    bit ill, rw;
    if (!rst_n) begin
      model_reset();
      return;
    end
    c = 0; ill = 1'b0; b = int'(ba);
    if (cke && !cs_n) begin
      case ({ras_n, cas_n, we_n})
        E_ACT:   c = 1;
        E_RD:    c = 2;
        E_WR:    c = 3;
        E_PRE:   c = addr[10] ? 5 : 4;
        E_REF:   c = 6;
        E_MRS:   c = 7;
        E_ILL:   ill = 1'b1;
        default: c = 0;
      endcase
    end
    rw = (c == 2 || c == 3);
    code = 0;
    if (ill)                          code = 1;
    else if (c == 1 && m_open[b])     code = 2;
    else if (rw && !m_open[b])        code = 3;
    else if (c == 6 && m_open != 0)   code = 4;
    else if (TCHK && rw && cyc - last_act[b] < int'(t_rcd))      code = 5;
    else if (TCHK && c == 4 && cyc - last_act[b] < int'(t_ras))  code = 6;
    else if (TCHK && c == 1 && cyc - last_pre[b] < int'(t_rp))   code = 7;
    else if (TCHK && c != 0 && cyc - last_ref < int'(t_rfc))     code = 8;
    else if (TCHK && rw && cyc - last_ccd < int'(t_ccd))         code = 9;

    case (c)
      1: begin m_open[b] = 1'b1; last_act[b] = cyc; end
      4: begin m_open[b] = 1'b0; last_pre[b] = cyc; end
      5: begin m_open = '0; for (int i = 0; i < 4; i++) last_pre[i] = cyc; end
      6: last_ref = cyc;
      default: ;
    endcase
    if (rw) last_ccd = cyc;
    if (c == 2) begin
      if (cyc + int'(rd_lat) < SCHED)     sched[cyc + int'(rd_lat)] = 1'b1;
      if (cyc + int'(rd_lat) + 1 < SCHED) sched[cyc + int'(rd_lat) + 1] = 1'b1;
    end
    exp_rd    = (cyc < SCHED) ? int'(sched[cyc]) : 0;
    exp_valid = (c != 0) ? 1 : 0;
    exp_cmd   = c;
    exp_ba    = b;
    exp_addr  = int'(addr);
    exp_open  = int'(m_open);
    exp_err   = (code != 0) ? 1 : 0;
    exp_code  = code;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid", 32'(cmd_valid_o), exp_valid);
      if (exp_valid != 0) begin
        chk("cmd", 32'(cmd_o), exp_cmd);
        chk("cmd_ba", 32'(cmd_ba_o), exp_ba);
        chk("cmd_addr", 32'(cmd_addr_o), exp_addr);
      end
      chk("bank_open", 32'(bank_open_o), exp_open);
      chk("rd_en", 32'(rd_en_o), exp_rd);
      chk("err", 32'(err_o), exp_err);
      if (exp_err != 0) chk("err_code", 32'(err_code_o), exp_code);
    end
  end

  task automatic idle();
    cke = 1'b1; cs_n = 1'b1; {ras_n, cas_n, we_n} = E_NOP;
  endtask

  task automatic nops(input int n);
    idle();
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic issue(input logic [2:0] enc, input logic [1:0] b, input logic [15:0] a);
    cke = 1'b1; cs_n = 1'b0; {ras_n, cas_n, we_n} = enc; ba = b; addr = a;
    tick();
    idle();
  endtask

  task automatic rnd_drive();
    int r, w;
    r = $urandom_range(0, 99);
    ba = 2'($urandom);
    addr = 16'($urandom);
    {ras_n, cas_n, we_n} = 3'($urandom);
    if (r < 8) begin
      cke = 1'b0; cs_n = 1'($urandom);
    end else if (r < 30) begin
      cke = 1'b1; cs_n = 1'b1;
    end else begin
      cke = 1'b1; cs_n = 1'b0;
      w = $urandom_range(0, 99);
      if (w < 22)      {ras_n, cas_n, we_n} = E_ACT;
      else if (w < 44) {ras_n, cas_n, we_n} = E_RD;
      else if (w < 56) {ras_n, cas_n, we_n} = E_WR;
      else if (w < 74) begin
        {ras_n, cas_n, we_n} = E_PRE;
        addr[10] = ($urandom_range(0, 3) == 0);
      end
      else if (w < 80) {ras_n, cas_n, we_n} = E_REF;
      else if (w < 83) {ras_n, cas_n, we_n} = E_MRS;
      else if (w < 86) {ras_n, cas_n, we_n} = E_ILL;
      else             {ras_n, cas_n, we_n} = E_NOP;
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_valid", 32'(cmd_valid_o), 0);
    chk("rst_cmd", 32'(cmd_o), 0);
    chk("rst_ba", 32'(cmd_ba_o), 0);
    chk("rst_addr", 32'(cmd_addr_o), 0);
    chk("rst_open", 32'(bank_open_o), 0);
    chk("rst_rd_en", 32'(rd_en_o), 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_code", 32'(err_code_o), 0);
  endtask

  initial begin
    model_reset();
    idle();
    rst_n = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    rst_n = 1'b1;
    chk_reset_outputs();

    // ACT then RD after tRCD; read window 5 and 6 cycles after the RD edge
    issue(E_ACT, 2'd1, 16'h0123);
    chk("act_cmd", 32'(cmd_o), 1);
    chk("act_open", 32'(bank_open_o), 32'h2);
    chk("act_err", 32'(err_o), 0);
    nops(3);
    issue(E_RD, 2'd1, 16'h0040);
    chk("rd_cmd", 32'(cmd_o), 2);
    chk("rd_addr", 32'(cmd_addr_o), 32'h40);
    chk("rd_err", 32'(err_o), 0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("rd_window", 32'(rd_en_o), (k == 5 || k == 6) ? 1 : 0);
    end
    issue(E_PRE, 2'd1, 16'h0000);
    chk("pre_open", 32'(bank_open_o), 0);

    // Deselected bus with undriven command pins
    cs_n = 1'b1; ras_n = 1'bx; cas_n = 1'bx; we_n = 1'bx;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("desel_valid", 32'(cmd_valid_o), 0);
      chk("desel_no_x", 32'($isunknown({cmd_valid_o, cmd_o, cmd_ba_o, cmd_addr_o,
                                         bank_open_o, rd_en_o, err_o, err_code_o})), 0);
    end

    issue(E_ACT, 2'd0, 16'h0011);
    issue(E_ACT, 2'd2, 16'h0022);
    nops(2);
    issue(E_PRE, 2'd0, 16'h0400);
    chk("prea_cmd", 32'(cmd_o), 5);
    chk("prea_open", 32'(bank_open_o), 0);
    issue(E_REF, 2'd0, 16'h0000);
    chk("ref_err", 32'(err_o), 0);
    nops(10);
    issue(E_RD, 2'd3, 16'h0010);
    chk("rd_closed_err", 32'(err_o), 1);
    chk("rd_closed_code", 32'(err_code_o), 3);
    issue(E_ACT, 2'd0, 16'h0055);
    chk("act0_err", 32'(err_o), 0);
    chk("act0_open", 32'(bank_open_o), 32'h1);
    issue(E_ACT, 2'd0, 16'h0066);
    chk("act_open_err", 32'(err_o), 1);
    chk("act_open_code", 32'(err_code_o), 2);
    issue(E_ILL, 2'd1, 16'h0000);
    chk("ill_valid", 32'(cmd_valid_o), 0);
    chk("ill_code", 32'(err_code_o), 1);

    // tRAS boundary: 5 cycles too early, 6 cycles legal
    issue(E_ACT, 2'd2, 16'h0200);
    nops(4);
    issue(E_PRE, 2'd2, 16'h0000);
    chk("tras5_err", 32'(err_o), TCHK ? 1 : 0);
    if (err_o) chk("tras5_code", 32'(err_code_o), 6);
    nops(3);
    issue(E_ACT, 2'd2, 16'h0201);
    nops(5);
    issue(E_PRE, 2'd2, 16'h0000);
    chk("tras6_err", 32'(err_o), 0);

    // tRFC boundary: ACT 9 cycles after REF too early, 10 cycles legal
    issue(E_PRE, 2'd0, 16'h0400);
    issue(E_REF, 2'd0, 16'h0000);
    chk("ref2_err", 32'(err_o), 0);
    nops(8);
    issue(E_ACT, 2'd1, 16'h0300);
    chk("trfc9_code", 32'(err_code_o), TCHK ? 8 : 0);
    issue(E_ACT, 2'd2, 16'h0301);
    chk("trfc10_err", 32'(err_o), 0);

    // Reset in the middle of a pending read window
    nops(3);
    issue(E_RD, 2'd1, 16'h0008);
    chk("rd2_err", 32'(err_o), 0);
    nops(2);
    rst_n = 1'b0;
    tick();
    chk_reset_outputs();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("rst_abort_rd_en", 32'(rd_en_o), 0);
    end

    // Random traffic under varying timing parameters
    for (int ph = 0; ph < 4; ph++) begin
      t_rcd  = 5'($urandom_range(0, 7));
      t_rp   = 5'($urandom_range(0, 7));
      t_ras  = 5'($urandom_range(0, 9));
      t_rfc  = 5'($urandom_range(0, 12));
      t_ccd  = 5'($urandom_range(0, 4));
      rd_lat = 5'($urandom_range(2, 30));
      idle();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int n = 0; n < 600; n++) begin
        rst_n = ($urandom_range(0, 299) != 0);
        rnd_drive();
        tick();
      end
      rst_n = 1'b1;
    end

    idle();
    nops(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
